// File: rtl/bch_syndrome_gen.sv
// bch_syndrome_gen
// Streaming syndrome generator for the BCH decoder front end. Received hard
// bits arrive P per beat, MSB (earliest position) first. Each syndrome
// S_j (j = 1..NSYN) is accumulated in GF(2^m) by parallel Horner evaluation:
//     S_j <- S_j * alpha^(jP) xor sum_k in_bits[k] * alpha^(jk)
// The code is runtime-selectable: n=63 (m=6,t=2), n=255 (m=8,t=2), n=1023 (m=10,t=4).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   code[1:0]           1: n=63, 2: n=255, 3 or 0: n=1023 (latched on first beat)
//   in_valid/in_ready   input beat handshake
//   in_bits[P-1:0]      received bits, in_bits[P-1] is the earliest position
//   in_last             final beat of the frame
//   out_valid/out_ready syndrome handshake towards the Berlekamp stage
//   syn                 packed syndromes, S1 in the lowest M_MAX-bit field
//   syn_zero            all syndromes zero (qualified by out_valid)
//   frame_err           in_last did not coincide with the nominal last beat
module bch_syndrome_gen #(
    parameter int P     = 8,
    parameter int M_MAX = 10,
    parameter int NSYN  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              code,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [P-1:0]            in_bits,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NSYN*M_MAX-1:0]   syn,
    output logic                    syn_zero,
    output logic                    frame_err
);

    localparam int CW = 11;
    localparam logic [CW-1:0] LAST6  = CW'(64 / P - 1);
    localparam logic [CW-1:0] LAST8  = CW'(256 / P - 1);
    localparam logic [CW-1:0] LAST10 = CW'(1024 / P - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    // Multiply by alpha = x in the field chosen by sel (1: m=6, 2: m=8, else m=10).
    // The operand is assumed to already lie inside the selected field.
    function automatic logic [M_MAX-1:0] mul_x(input logic [M_MAX-1:0] a, input logic [1:0] sel);
        logic [M_MAX:0] t;
        t = {a, 1'b0};
        case (sel)
            2'd1:    if (t[6])  t = t ^ 11'h043;
            2'd2:    if (t[8])  t = t ^ 11'h11D;
            default: if (t[10]) t = t ^ 11'h409;
        endcase
        return t[M_MAX-1:0];
    endfunction

    // alpha^e in the selected field; only evaluated on constants at elaboration.
    function automatic logic [M_MAX-1:0] alpha_pow(input int e, input logic [1:0] sel);
        logic [M_MAX-1:0] r;
        int order;
        int ee;
        order = (sel == 2'd1) ? 63 : (sel == 2'd2) ? 255 : 1023;
        ee    = e % order;
        r     = M_MAX'(1);
        for (int i = 0; i < ee; i++) r = mul_x(r, sel);
        return r;
    endfunction

    // Shift-and-add GF multiply, MSB first.
    function automatic logic [M_MAX-1:0] gf_mul(input logic [M_MAX-1:0] a, input logic [M_MAX-1:0] b,
                                                input logic [1:0] sel);
        logic [M_MAX-1:0] r;
        r = '0;
        for (int i = M_MAX - 1; i >= 0; i--) begin
            r = mul_x(r, sel);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    state_t                         state_q, state_d;
    logic [1:0]                     code_q, code_d;
    logic [CW-1:0]                  beat_cnt_q, beat_cnt_d;
    logic [NSYN-1:0][M_MAX-1:0]     syn_q, syn_d;
    logic                           frame_err_q, frame_err_d;
    logic                           ready_en_q, ready_en_d;

    logic                           accept;
    logic [1:0]                     sel_cur;
    logic [CW-1:0]                  beat_idx;
    logic [CW-1:0]                  last_idx;
    logic                           on_last_pos;
    logic                           frame_end;
    logic [P-1:0]                   bits_eff;
    logic [NSYN-1:0][M_MAX-1:0]     syn_next;

    assign accept = in_valid && in_ready;

    // While idle the live code input decides the field for the first beat;
    // afterwards the latched code is used so mid-frame changes are ignored.
    // The first beat carries the pad position, which never contributes.
    always_comb begin
        sel_cur  = (state_q == IDLE) ? ((code == 2'd0) ? 2'd3 : code) : code_q;
        beat_idx = (state_q == IDLE) ? '0 : beat_cnt_q;
        case (sel_cur)
            2'd1:    last_idx = LAST6;
            2'd2:    last_idx = LAST8;
            default: last_idx = LAST10;
        endcase
        on_last_pos = (beat_idx == last_idx);
        frame_end   = in_last || on_last_pos;
        bits_eff    = in_bits;
        if (state_q == IDLE) bits_eff[P-1] = 1'b0;
    end

    genvar gj, gk;
    generate
        for (gj = 0; gj < NSYN; gj++) begin : g_syn
            localparam logic [M_MAX-1:0] H6  = alpha_pow((gj + 1) * P, 2'd1);
            localparam logic [M_MAX-1:0] H8  = alpha_pow((gj + 1) * P, 2'd2);
            localparam logic [M_MAX-1:0] H10 = alpha_pow((gj + 1) * P, 2'd3);

            logic [M_MAX-1:0] term [P];
            logic [M_MAX-1:0] sum;
            logic [M_MAX-1:0] hmul;
            logic [M_MAX-1:0] prev;
            logic [M_MAX-1:0] nxt;

            for (gk = 0; gk < P; gk++) begin : g_term
                localparam logic [M_MAX-1:0] C6  = alpha_pow((gj + 1) * gk, 2'd1);
                localparam logic [M_MAX-1:0] C8  = alpha_pow((gj + 1) * gk, 2'd2);
                localparam logic [M_MAX-1:0] C10 = alpha_pow((gj + 1) * gk, 2'd3);
                assign term[gk] = !bits_eff[gk] ? '0 :
                                  (sel_cur == 2'd1) ? C6 :
                                  (sel_cur == 2'd2) ? C8 : C10;
            end

            // Horner step; t=2 codes pin the upper syndromes to zero.
            always_comb begin
                sum = '0;
                for (int k = 0; k < P; k++) sum = sum ^ term[k];
                case (sel_cur)
                    2'd1:    hmul = H6;
                    2'd2:    hmul = H8;
                    default: hmul = H10;
                endcase
                prev = (state_q == IDLE) ? '0 : syn_q[gj];
                nxt  = gf_mul(prev, hmul, sel_cur) ^ sum;
                if (gj >= 4 && sel_cur != 2'd3) nxt = '0;
            end

            assign syn_next[gj] = nxt;
        end
    endgenerate

    // Frame sequencing; syndromes only move on accepted beats.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        beat_cnt_d  = beat_cnt_q;
        syn_d       = syn_q;
        frame_err_d = frame_err_q;
        ready_en_d  = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    code_d      = sel_cur;
                    beat_cnt_d  = CW'(1);
                    syn_d       = syn_next;
                    frame_err_d = in_last != on_last_pos;
                    state_d     = frame_end ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    syn_d       = syn_next;
                    frame_err_d = in_last != on_last_pos;
                    if (frame_end) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= 2'd3;
            beat_cnt_q  <= '0;
            syn_q       <= '0;
            frame_err_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            beat_cnt_q  <= beat_cnt_d;
            syn_q       <= syn_d;
            frame_err_q <= frame_err_d;
            ready_en_q  <= ready_en_d;
        end
    end

    assign in_ready  = ready_en_q && (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign syn       = syn_q;
    assign syn_zero  = out_valid && (syn_q == '0);
    assign frame_err = out_valid && frame_err_q;

endmodule
